sysarray_feeder: RTL and testbench

Operand sequencer for the 4x3 output-stationary `sysarray`. It buffers one A (4xK) and one B (Kx3) operand pair, delivered one k-slice per handshake beat. It drives the array's clear and emits the diagonally skewed `a1..a4`, `b1..b3` streams. It pulses `done` in the cycle the array's `c1..c12` outputs hold the final C = A·B.

---
 rtl/sysarray_feeder.sv | 157 +++++++++++++++
 tb/tb_sysarray_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarray_feeder.sv
// Operand sequencer for the 4x3 output-stationary sysarray: buffers A/B k-slices,
// clears the array, streams skewed a1..a4 / b1..b3 and pulses done. Optional: SYSARRAY_FEEDER_REPLAY_EN.
module sysarray_feeder #(
    parameter int unsigned data_size = 8,
    parameter int unsigned k_max     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [4*data_size-1:0] ld_a,
    input  logic [3*data_size-1:0] ld_b,
    input  logic                   ld_last,
`ifdef SYSARRAY_FEEDER_REPLAY_EN
    input  logic                   replay,
`endif
    output logic                   arr_clr,
    output logic [data_size-1:0]   a1,
    output logic [data_size-1:0]   a2,
    output logic [data_size-1:0]   a3,
    output logic [data_size-1:0]   a4,
    output logic [data_size-1:0]   b1,
    output logic [data_size-1:0]   b2,
    output logic [data_size-1:0]   b3,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned PW = (k_max > 1) ? $clog2(k_max) : 1;
    localparam int unsigned KW = $clog2(k_max + 1);
    localparam int unsigned TW = $clog2(k_max + 5);

    typedef enum logic [1:0] {LOAD, CLEAR, FEED, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr;
    logic [KW-1:0]   k_len;
    logic [TW-1:0]   t, t_nxt;
    logic            accept, load_end, start_replay;

    logic [3:0][data_size-1:0] buf_a [k_max];
    logic [2:0][data_size-1:0] buf_b [k_max];

    logic [3:0][data_size-1:0] a_q, a_nxt;
    logic [2:0][data_size-1:0] b_q, b_nxt;
    logic                      clr_nxt, ready_nxt, busy_nxt, done_nxt;

    assign accept   = (state == LOAD) && ld_valid;
    assign load_end = accept && (ld_last || (wr_ptr == PW'(k_max - 1)));

`ifdef SYSARRAY_FEEDER_REPLAY_EN
    logic ran;

    // Replay is only meaningful once a buffer has been fully fed at least once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              ran <= 1'b0;
        else if (state == DONE) ran <= 1'b1;
    end

    assign start_replay = (state == LOAD) && !ld_valid && replay && (wr_ptr == '0) && ran;
`else
    assign start_replay = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_end || start_replay) state_nxt = CLEAR;
            CLEAR:   state_nxt = FEED;
            FEED:    if (t == TW'(k_len) + TW'(4)) state_nxt = DONE;
            DONE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    assign t_nxt = (state == FEED) ? t + TW'(1) : '0;

    // Output logic: next values of the registered outputs, skewed by row/column index
    always_comb begin
        logic [TW-1:0] tmi;
        tmi       = '0;
        a_nxt     = '0;
        b_nxt     = '0;
        clr_nxt   = (state_nxt == CLEAR);
        ready_nxt = (state_nxt == LOAD);
        busy_nxt  = (state_nxt != LOAD);
        done_nxt  = (state_nxt == DONE);
        if (state_nxt == FEED) begin
            for (int i = 0; i < 4; i++) begin
                tmi = t_nxt - TW'(i);
                if ((t_nxt >= TW'(i)) && (tmi < TW'(k_len)))
                    a_nxt[2'(i)] = buf_a[PW'(tmi)][2'(i)];
            end
            for (int j = 0; j < 3; j++) begin
                tmi = t_nxt - TW'(j);
                if ((t_nxt >= TW'(j)) && (tmi < TW'(k_len)))
                    b_nxt[2'(j)] = buf_b[PW'(tmi)][2'(j)];
            end
        end
    end

    // Load pointer, captured K and feed counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            k_len  <= '0;
            t      <= '0;
        end else begin
            t <= t_nxt;
            if (accept) wr_ptr <= load_end ? '0 : wr_ptr + PW'(1);
            if (load_end) k_len <= KW'(wr_ptr) + KW'(1);
        end
    end

    // Slice buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_a[wr_ptr] <= ld_a;
            buf_b[wr_ptr] <= ld_b;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            arr_clr  <= 1'b0;
            ld_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            arr_clr  <= clr_nxt;
            ld_ready <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];

endmodule

// File: tb/tb_sysarray_feeder.sv
// Randomized self-checking bench for sysarray_feeder; array results are reconstructed from the
// observed skewed streams and compared to a plain matrix product.
module tb_sysarray_feeder;

    localparam int unsigned DS = 8;
    localparam int unsigned KM = 8;
    localparam longint MASK = (64'd1 << (2*DS+1)) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            ld_valid, ld_last, ld_ready;
    logic [4*DS-1:0] ld_a;
    logic [3*DS-1:0] ld_b;
    logic            arr_clr, busy, done;
    logic [DS-1:0]   a1, a2, a3, a4, b1, b2, b3;
    logic            replay;

    wire [DS-1:0] av [4];
    wire [DS-1:0] bv [3];
    assign av[0] = a1; assign av[1] = a2; assign av[2] = a3; assign av[3] = a4;
    assign bv[0] = b1; assign bv[1] = b2; assign bv[2] = b3;

    sysarray_feeder #(.data_size(DS), .k_max(KM)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_a(ld_a), .ld_b(ld_b), .ld_last(ld_last),
`ifdef SYSARRAY_FEEDER_REPLAY_EN
        .replay(replay),
`endif
        .arr_clr(arr_clr),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    int  A [4][KM];
    int  B [KM][3];
    int  cobs [12];
    int  last_k;
    bit  vpat [$];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ab_zero(input string tag);
        for (int i = 0; i < 4; i++) check_val($sformatf("%s a%0d", tag, i+1), longint'(av[i]), 0);
        for (int j = 0; j < 3; j++) check_val($sformatf("%s b%0d", tag, j+1), longint'(bv[j]), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, " ld_ready"}, longint'(ld_ready), 1);
        check_val({tag, " arr_clr"}, longint'(arr_clr), 0);
        check_val({tag, " busy"}, longint'(busy), 0);
        check_val({tag, " done"}, longint'(done), 0);
        check_ab_zero(tag);
    endtask

    // Offer k beats, valid pattern from vpat if present, else random gaps; returns in the CLEAR cycle.
    task automatic do_load(input int k, input bit use_last, input int gap_pct);
        int sent;
        bit v;
        sent = 0;
        while (sent < k) begin
            check_val("load ld_ready", longint'(ld_ready), 1);
            check_val("load busy", longint'(busy), 0);
            if (vpat.size() > 0)   v = vpat.pop_front();
            else if (gap_pct == 0) v = 1'b1;
            else                   v = ($urandom_range(99) >= gap_pct);
            for (int i = 0; i < 4; i++) ld_a[i*DS +: DS] = DS'(A[i][sent]);
            for (int j = 0; j < 3; j++) ld_b[j*DS +: DS] = DS'(B[sent][j]);
            ld_valid = v;
            ld_last  = v && use_last && (sent == k-1);
            @(posedge clk); #1;
            if (v) sent++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Checks CLEAR, FEED streams, DONE and return to LOAD; rebuilds C from observed streams.
    task automatic check_run(input int k);
        int     ha [4][KM+5];
        int     hb [3][KM+5];
        longint acc, ref_c, pa, pb;
        check_val("clr arr_clr", longint'(arr_clr), 1);
        check_val("clr ld_ready", longint'(ld_ready), 0);
        check_val("clr busy", longint'(busy), 1);
        check_val("clr done", longint'(done), 0);
        check_ab_zero("clr");
        // Offered beats outside LOAD must be ignored
        ld_valid = 1'b1; ld_last = 1'b1;
        for (int t = 0; t <= k+4; t++) begin
            @(posedge clk); #1;
            check_val("feed arr_clr", longint'(arr_clr), 0);
            check_val("feed done", longint'(done), 0);
            check_val("feed ld_ready", longint'(ld_ready), 0);
            for (int i = 0; i < 4; i++) begin
                check_val($sformatf("a%0d t%0d", i+1, t), longint'(av[i]),
                          (t-i >= 0 && t-i < k) ? longint'(A[i][t-i]) : 0);
                ha[i][t] = int'(av[i]);
            end
            for (int j = 0; j < 3; j++) begin
                check_val($sformatf("b%0d t%0d", j+1, t), longint'(bv[j]),
                          (t-j >= 0 && t-j < k) ? longint'(B[t-j][j]) : 0);
                hb[j][t] = int'(bv[j]);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        @(posedge clk); #1;
        check_val("done pulse", longint'(done), 1);
        check_val("done busy", longint'(busy), 1);
        check_val("done arr_clr", longint'(arr_clr), 0);
        check_ab_zero("done");
        // PE(i,j) sees row i delayed j cycles and column j delayed i cycles
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                for (int t = 0; t <= k+4; t++) begin
                    pa = (t-j >= 0) ? longint'(ha[i][t-j]) : 0;
                    pb = (t-i >= 0) ? longint'(hb[j][t-i]) : 0;
                    acc = acc + pa * pb;
                end
                ref_c = 0;
                for (int kk = 0; kk < k; kk++) ref_c = ref_c + longint'(A[i][kk]) * longint'(B[kk][j]);
                cobs[i*3+j] = int'(acc & MASK);
                check_val($sformatf("c%0d", i*3+j+1), acc & MASK, ref_c & MASK);
            end
        @(posedge clk); #1;
        check_val("post ld_ready", longint'(ld_ready), 1);
        check_val("post busy", longint'(busy), 0);
        check_val("post done", longint'(done), 0);
        last_k = k;
    endtask

    task automatic set_k1;
        for (int i = 0; i < 4; i++) A[i][0] = i + 1;
        for (int j = 0; j < 3; j++) B[0][j] = j + 5;
    endtask

    task automatic check_k1_consts(input string tag);
        int exp_c [12];
        exp_c = '{5, 6, 7, 10, 12, 14, 15, 18, 21, 20, 24, 28};
        for (int n = 0; n < 12; n++) check_val($sformatf("%s c%0d", tag, n+1), longint'(cobs[n]), longint'(exp_c[n]));
    endtask

    initial begin
        int k;
        bit ul;
        reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; replay = 1'b0;
        ld_a = '0; ld_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("idle");

`ifdef SYSARRAY_FEEDER_REPLAY_EN
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        check_val("early replay ld_ready", longint'(ld_ready), 1);
        @(posedge clk); #1;
        check_val("early replay arr_clr", longint'(arr_clr), 0);
`endif

        // K = 1 outer product
        set_k1();
        do_load(1, 1'b1, 0);
        check_run(1);
        check_k1_consts("k1");

        // K = 3, B identity
        A[0][0] = 1; A[0][1] = 2; A[0][2] = 3;
        A[1][0] = 4; A[1][1] = 5; A[1][2] = 6;
        A[2][0] = 7; A[2][1] = 8; A[2][2] = 9;
        A[3][0] = 1; A[3][1] = 0; A[3][2] = 1;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) B[r][c] = (r == c) ? 1 : 0;
        do_load(3, 1'b1, 0);
        check_run(3);

        // Backpressure, K = 4 all ones
        for (int r = 0; r < KM; r++) begin
            for (int i = 0; i < 4; i++) A[i][r] = 1;
            for (int j = 0; j < 3; j++) B[r][j] = 1;
        end
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_load(4, 1'b1, 0);
        check_run(4);
        check_val("bp c1", longint'(cobs[0]), 4);

        // Implicit last at k_max
        for (int r = 0; r < KM; r++) begin
            for (int i = 0; i < 4; i++) A[i][r] = 2;
            for (int j = 0; j < 3; j++) B[r][j] = 3;
        end
        do_load(KM, 1'b0, 0);
        check_run(KM);
        check_val("implicit c12", longint'(cobs[11]), 48);

        // Reset in FEED t = 2
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) A[i][r] = int'($urandom_range(255));
            for (int j = 0; j < 3; j++) B[r][j] = int'($urandom_range(255));
        end
        do_load(3, 1'b1, 0);
        repeat (3) begin @(posedge clk); #1; end
        check_val("pre-reset busy", longint'(busy), 1);
        reset = 1'b1; ld_valid = 1'b0;
        #1;
        check_reset_vals("midreset");
        #1;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check_val("after reset done", longint'(done), 0);
            check_val("after reset ld_ready", longint'(ld_ready), 1);
        end
        set_k1();
        do_load(1, 1'b1, 0);
        check_run(1);
        check_k1_consts("k1 after reset");

`ifdef SYSARRAY_FEEDER_REPLAY_EN
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        check_run(last_k);
        check_k1_consts("replay");
`endif

        // Randomized runs
        for (int run = 0; run < 20; run++) begin
            k  = int'($urandom_range(1, KM));
            ul = (k < int'(KM)) ? 1'b1 : 1'($urandom_range(1));
            for (int r = 0; r < k; r++) begin
                for (int i = 0; i < 4; i++) A[i][r] = int'($urandom_range(255));
                for (int j = 0; j < 3; j++) B[r][j] = int'($urandom_range(255));
            end
            do_load(k, ul, 30);
            check_run(k);
`ifdef SYSARRAY_FEEDER_REPLAY_EN
            if (run % 5 == 4) begin
                replay = 1'b1;
                @(posedge clk); #1;
                replay = 1'b0;
                check_run(last_k);
            end
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
